// File: rtl/sram_controller.sv
// sram_controller: bridges a 32-bit MEM-stage word access onto a 16-bit SRAM
// as two sequential half-word accesses (low half, then high half), each held
// for WAIT_CYCLES clocks. ready stays low while the access is in flight.
module sram_controller #(
   parameter int unsigned ADDR_BASE   = 1024,
   parameter int unsigned SRAM_ADDR_W = 18,
   parameter int unsigned WAIT_CYCLES = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_we_n
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic        op_wr, op_wr_nxt;
   logic        half;
   logic        last;
   logic [31:0] offset;
   logic        addr_unused;

   // Byte offset from the SRAM window base; wraps mod 2^32 for addresses below it.
   assign offset = address - 32'(ADDR_BASE);

   // Word index is offset >> 2; only its low SRAM_ADDR_W-1 bits reach the pins.
   assign sram_addr   = {offset[SRAM_ADDR_W:2], half};
   assign addr_unused = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

   assign last = (cnt == 32'(WAIT_CYCLES - 1));

   // State, wait counter and latched operation register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         op_wr <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         op_wr <= op_wr_nxt;
      end
   end

   // Load data capture: each half is sampled on the final cycle of its access.
   always_ff @(posedge clk) begin
      if (rst) begin
         read_data <= '0;
      end else if (!op_wr && last) begin
         if (state == LOW)
            read_data[15:0] <= sram_dq_in;
         else if (state == HIGH)
            read_data[31:16] <= sram_dq_in;
      end
   end

   // Next-state sequencing and SRAM/pipeline handshake outputs.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      op_wr_nxt   = op_wr;
      half        = 1'b0;
      ready       = 1'b0;
      sram_we_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_dq_out = 16'h0000;

      case (state)
         IDLE: begin
            ready = ~wr_en & ~rd_en;
            if (wr_en | rd_en) begin
               // A request with both levels set is treated as a write.
               op_wr_nxt = wr_en;
               state_nxt = LOW;
               cnt_nxt   = '0;
            end
         end

         LOW: begin
            if (op_wr) begin
               sram_we_n   = 1'b0;
               sram_dq_oe  = 1'b1;
               sram_dq_out = write_data[15:0];
            end
            if (last) begin
               state_nxt = HIGH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 32'd1;
            end
         end

         HIGH: begin
            half = 1'b1;
            if (op_wr) begin
               sram_we_n   = 1'b0;
               sram_dq_oe  = 1'b1;
               sram_dq_out = write_data[31:16];
            end
            if (last) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 32'd1;
            end
         end

         DONE: begin
            // One-cycle release; requests are not looked at until IDLE.
            ready     = 1'b1;
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule
